// File: rtl/sa2_host_ctrl.sv
// sa2_host_ctrl: byte-stream loader, run sequencer and result drainer for the 2x2 systolic array.
// Loads 16 A + 9 B bytes, runs the array with a timeout, then streams c11,c12,c21,c22.
module sa2_host_ctrl #(
   parameter int DW       = 8,
   parameter int WAIT_MAX = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic [DW-1:0] a11, a12, a13, a14,
   output logic [DW-1:0] a21, a22, a23, a24,
   output logic [DW-1:0] a31, a32, a33, a34,
   output logic [DW-1:0] a41, a42, a43, a44,
   output logic [DW-1:0] b11, b12, b13,
   output logic [DW-1:0] b21, b22, b23,
   output logic [DW-1:0] b31, b32, b33,
   output logic          active_sa2,
   input  logic          done_sa2,
   input  logic [DW-1:0] c11, c12, c21, c22,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready,
   output logic          busy,
   output logic          err
);
   localparam int TW = $clog2(WAIT_MAX + 1);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
   state_t        state;
   logic [DW-1:0] a_r [16];
   logic [DW-1:0] b_r [9];
   logic [DW-1:0] c_r [4];
   logic [4:0]    cnt;
   logic [1:0]    idx;
   logic [TW-1:0] timer;
   logic          in_xfer, out_xfer;
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         active_sa2 <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         busy       <= 1'b0;
         err        <= 1'b0;
         cnt        <= '0;
         idx        <= '0;
         timer      <= '0;
         for (int i = 0; i < 16; i++) a_r[i] <= '0;
         for (int i = 0; i < 9; i++) b_r[i] <= '0;
         for (int i = 0; i < 4; i++) c_r[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_xfer) begin
                  a_r[0] <= in_data;
                  err    <= 1'b0;
                  busy   <= 1'b1;
                  cnt    <= 5'd1;
                  state  <= LOAD;
               end
            end
            LOAD: if (in_xfer) begin
               // bytes 16..24 have cnt[4] set, so cnt[3:0] is already the B index 0..8
               if (!cnt[4]) a_r[cnt[3:0]] <= in_data;
               else b_r[cnt[3:0]] <= in_data;
               cnt <= cnt + 5'd1;
               if (cnt == 5'd24) begin
                  in_ready   <= 1'b0;
                  active_sa2 <= 1'b1;
                  timer      <= '0;
                  state      <= RUN;
               end
            end
            RUN: begin
               if (done_sa2) begin
                  c_r[0]     <= c11;
                  c_r[1]     <= c12;
                  c_r[2]     <= c21;
                  c_r[3]     <= c22;
                  active_sa2 <= 1'b0;
                  out_valid  <= 1'b1;
                  out_data   <= c11;
                  idx        <= '0;
                  state      <= DRAIN;
               end else if (timer == TW'(WAIT_MAX - 1)) begin
                  active_sa2 <= 1'b0;
                  err        <= 1'b1;
                  busy       <= 1'b0;
                  in_ready   <= 1'b1;
                  state      <= IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            DRAIN: if (out_xfer) begin
               if (idx == 2'd3) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end else begin
                  idx      <= idx + 2'd1;
                  out_data <= c_r[idx + 2'd1];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
   assign a11 = a_r[0];  assign a12 = a_r[1];  assign a13 = a_r[2];  assign a14 = a_r[3];
   assign a21 = a_r[4];  assign a22 = a_r[5];  assign a23 = a_r[6];  assign a24 = a_r[7];
   assign a31 = a_r[8];  assign a32 = a_r[9];  assign a33 = a_r[10]; assign a34 = a_r[11];
   assign a41 = a_r[12]; assign a42 = a_r[13]; assign a43 = a_r[14]; assign a44 = a_r[15];
   assign b11 = b_r[0];  assign b12 = b_r[1];  assign b13 = b_r[2];
   assign b21 = b_r[3];  assign b22 = b_r[4];  assign b23 = b_r[5];
   assign b31 = b_r[6];  assign b32 = b_r[7];  assign b33 = b_r[8];
endmodule

// File: tb/tb_sa2_host_ctrl.sv
// tb_sa2_host_ctrl: directed scenarios for the systolic-array host controller.
module tb_sa2_host_ctrl;
   localparam int WM = 8;
   logic       clk = 0, rst = 0;
   logic       in_valid = 0, done_sa2 = 0, out_ready = 0;
   logic [7:0] in_data = 0;
   logic [7:0] c_in [4] = '{8'h0, 8'h0, 8'h0, 8'h0};
   logic [7:0] a_o [16];
   logic [7:0] b_o [9];
   logic [7:0] c_exp [4];
   logic       in_ready, active_sa2, out_valid, busy, err;
   logic [7:0] out_data;
   int         checks = 0, errors = 0;

   always #5 clk = ~clk;

   sa2_host_ctrl #(.DW(8), .WAIT_MAX(WM)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .a11(a_o[0]), .a12(a_o[1]), .a13(a_o[2]), .a14(a_o[3]),
      .a21(a_o[4]), .a22(a_o[5]), .a23(a_o[6]), .a24(a_o[7]),
      .a31(a_o[8]), .a32(a_o[9]), .a33(a_o[10]), .a34(a_o[11]),
      .a41(a_o[12]), .a42(a_o[13]), .a43(a_o[14]), .a44(a_o[15]),
      .b11(b_o[0]), .b12(b_o[1]), .b13(b_o[2]),
      .b21(b_o[3]), .b22(b_o[4]), .b23(b_o[5]),
      .b31(b_o[6]), .b32(b_o[7]), .b33(b_o[8]),
      .active_sa2(active_sa2), .done_sa2(done_sa2),
      .c11(c_in[0]), .c12(c_in[1]), .c21(c_in[2]), .c22(c_in[3]),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .busy(busy), .err(err)
   );

   task automatic send(input logic [7:0] d);
      int g = 0;
      @(negedge clk);
      in_valid = 1;
      in_data  = d;
      while (!in_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL send_wait: in_ready=%b for byte %0d, want 1", in_ready, d);
      end
      @(posedge clk);
   endtask

   // bytes 1..25; optional gaps, err-clear check after byte 1, done pulse after byte pulse_at+1
   task automatic load(input bit gaps, input bit chk_err, input int pulse_at);
      for (int k = 0; k < 25; k++) begin
         send(8'(k + 1));
         if (chk_err && k == 0) begin
            @(negedge clk);
            in_valid = 0;
            checks++;
            if (err !== 1'b0 || busy !== 1'b1) begin
               errors++;
               $display("FAIL err_clear: err=%b busy=%b, want err=0 busy=1", err, busy);
            end
         end
         if (k == pulse_at) begin
            @(negedge clk);
            in_valid = 0;
            done_sa2 = 1;
            c_in = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
            @(negedge clk);
            done_sa2 = 0;
            checks++;
            if (out_valid !== 1'b0 || active_sa2 !== 1'b0 || busy !== 1'b1) begin
               errors++;
               $display("FAIL done_in_load: out_valid=%b active=%b busy=%b, want 0 0 1", out_valid, active_sa2, busy);
            end
         end
         if (gaps && k[0] && k != 24) begin
            @(negedge clk);
            in_valid = 0;
         end
      end
   endtask

   // array model: done sampled on the k-th RUN edge with result r0..r3
   task automatic respond(input int k, input bit junk, input logic [7:0] r0, r1, r2, r3);
      int act = 0;
      for (int i = 1; i <= k; i++) begin
         @(negedge clk);
         in_valid = junk;
         in_data  = 8'hEE;
         if (active_sa2 === 1'b1) act++;
         if (i == k) begin
            done_sa2 = 1;
            c_in = '{r0, r1, r2, r3};
         end
      end
      @(negedge clk);
      done_sa2 = 0;
      in_valid = 0;
      c_in = '{8'h5A, 8'h5A, 8'h5A, 8'h5A};
      checks++;
      if (act != k) begin
         errors++;
         $display("FAIL active_run: active high %0d cycles, want %0d", act, k);
      end
      checks++;
      if (active_sa2 !== 1'b0 || out_valid !== 1'b1 || out_data !== r0) begin
         errors++;
         $display("FAIL handoff: active=%b out_valid=%b out_data=%h, want 0 1 %h", active_sa2, out_valid, out_data, r0);
      end
      c_exp = '{r0, r1, r2, r3};
   endtask

   task automatic drain(input bit stall);
      int n = 0, guard = 0;
      logic [7:0] held = 0;
      bit was_stall = 0;
      while (n < 4 && guard < 100) begin
         @(negedge clk);
         guard++;
         if (was_stall) begin
            checks++;
            if (out_data !== held) begin
               errors++;
               $display("FAIL stall_hold: out_data=%h, want %h", out_data, held);
            end
         end
         out_ready = stall ? guard[0] : 1'b1;
         was_stall = 0;
         if (out_valid && out_ready) begin
            checks++;
            if (out_data !== c_exp[n]) begin
               errors++;
               $display("FAIL out_byte%0d: out_data=%h, want %h", n, out_data, c_exp[n]);
            end
            n++;
         end else if (out_valid) begin
            held = out_data;
            was_stall = 1;
         end
      end
      if (n < 4) begin
         checks++; errors++;
         $display("FAIL drain_timeout: got %0d bytes, want 4", n);
      end
      @(negedge clk);
      out_ready = 0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL drain_end: out_valid=%b busy=%b in_ready=%b, want 0 0 1", out_valid, busy, in_ready);
      end
   endtask

   task automatic test_reset;
      bit bad = 0;
      #3;
      for (int i = 0; i < 16; i++) if (a_o[i] !== 8'h0) bad = 1;
      for (int i = 0; i < 9; i++) if (b_o[i] !== 8'h0) bad = 1;
      checks++;
      if (bad || in_ready !== 0 || busy !== 0 || active_sa2 !== 0 || out_valid !== 0 || out_data !== 0 || err !== 0) begin
         errors++;
         $display("FAIL reset_vals: in_ready=%b busy=%b active=%b out_valid=%b out_data=%h err=%b ab_bad=%b, want all 0",
                  in_ready, busy, active_sa2, out_valid, out_data, err, bad);
      end
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: in_ready=%b busy=%b, want 1 0", in_ready, busy);
      end
   endtask

   task automatic test_basic;
      bit bad = 0;
      load(0, 0, -1);
      respond(6, 0, 8'h11, 8'h22, 8'h33, 8'h44);
      drain(0);
      for (int i = 0; i < 16; i++) if (a_o[i] !== 8'(i + 1)) bad = 1;
      for (int i = 0; i < 9; i++) if (b_o[i] !== 8'(i + 17)) bad = 1;
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL basic_ab: a11=%0d a44=%0d b11=%0d b33=%0d, want 1 16 17 25", a_o[0], a_o[15], b_o[0], b_o[8]);
      end
   endtask

   task automatic test_stall;
      bit bad = 0;
      load(1, 0, -1);
      respond(6, 1, 8'h11, 8'h22, 8'h33, 8'h44);
      drain(1);
      for (int i = 0; i < 16; i++) if (a_o[i] !== 8'(i + 1)) bad = 1;
      for (int i = 0; i < 9; i++) if (b_o[i] !== 8'(i + 17)) bad = 1;
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL stall_ab: a11=%0d a44=%0d b11=%0d b33=%0d, want 1 16 17 25", a_o[0], a_o[15], b_o[0], b_o[8]);
      end
   endtask

   task automatic test_timeout;
      int act = 0, ov = 0;
      load(0, 0, -1);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         in_valid = 0;
         if (active_sa2 === 1'b1) act++;
         if (out_valid === 1'b1) ov++;
      end
      checks++;
      if (act != WM) begin
         errors++;
         $display("FAIL timeout_active: active high %0d cycles, want %0d", act, WM);
      end
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || ov != 0) begin
         errors++;
         $display("FAIL timeout_state: err=%b busy=%b in_ready=%b out_valid_cycles=%0d, want 1 0 1 0", err, busy, in_ready, ov);
      end
      checks++;
      if (a_o[15] !== 8'd16 || b_o[8] !== 8'd25) begin
         errors++;
         $display("FAIL timeout_hold: a44=%0d b33=%0d, want 16 25", a_o[15], b_o[8]);
      end
      load(0, 1, -1);
      respond(3, 0, 8'h01, 8'h02, 8'h03, 8'h04);
      drain(0);
   endtask

   task automatic test_stray_done;
      @(negedge clk);
      done_sa2 = 1;
      c_in = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      @(negedge clk);
      done_sa2 = 0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || active_sa2 !== 1'b0) begin
         errors++;
         $display("FAIL done_in_idle: out_valid=%b busy=%b active=%b, want 0 0 0", out_valid, busy, active_sa2);
      end
      load(0, 0, 5);
      respond(2, 0, 8'h61, 8'h62, 8'h63, 8'h64);
      drain(1);
   endtask

   task automatic test_done_at_limit;
      load(1, 0, -1);
      respond(WM, 0, 8'hA1, 8'hA2, 8'hA3, 8'hA4);
      drain(1);
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL limit_err: err=%b, want 0", err);
      end
   endtask

   task automatic test_mid_reset;
      bit bad = 0;
      for (int k = 0; k < 12; k++) send(8'(k + 1));
      #2;
      in_valid = 0;
      rst = 0;
      #1;
      for (int i = 0; i < 16; i++) if (a_o[i] !== 8'h0) bad = 1;
      for (int i = 0; i < 9; i++) if (b_o[i] !== 8'h0) bad = 1;
      checks++;
      if (bad || in_ready !== 0 || busy !== 0 || active_sa2 !== 0 || out_valid !== 0 || err !== 0) begin
         errors++;
         $display("FAIL reset_in_load: in_ready=%b busy=%b active=%b out_valid=%b err=%b ab_bad=%b, want all 0",
                  in_ready, busy, active_sa2, out_valid, err, bad);
      end
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      load(0, 0, -1);
      respond(4, 0, 8'h71, 8'h72, 8'h73, 8'h74);
      drain(0);
      checks++;
      if (a_o[0] !== 8'd1 || a_o[10] !== 8'd11 || b_o[8] !== 8'd25) begin
         errors++;
         $display("FAIL reload_ab: a11=%0d a33=%0d b33=%0d, want 1 11 25", a_o[0], a_o[10], b_o[8]);
      end
      load(0, 0, -1);
      respond(3, 0, 8'h81, 8'h82, 8'h83, 8'h84);
      @(negedge clk);
      out_ready = 1;
      @(posedge clk);
      #2;
      out_ready = 0;
      rst = 0;
      #1;
      checks++;
      if (out_valid !== 0 || out_data !== 0 || busy !== 0 || active_sa2 !== 0 || a_o[0] !== 0 || b_o[8] !== 0) begin
         errors++;
         $display("FAIL reset_in_drain: out_valid=%b out_data=%h busy=%b active=%b a11=%h b33=%h, want all 0",
                  out_valid, out_data, busy, active_sa2, a_o[0], b_o[8]);
      end
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      load(1, 0, -1);
      respond(5, 0, 8'h91, 8'h92, 8'h93, 8'h94);
      drain(1);
   endtask

   initial begin
      test_reset;
      test_basic;
      test_stall;
      test_timeout;
      test_stray_done;
      test_done_at_limit;
      test_mid_reset;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end
endmodule
